mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 35 +++
 rtl/mem_access.sv | 141 ++++++++++++++
 tb/tb_mem_access.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Core request / response and memory port bundle for mem_access.
// The slave modport is the block's view; the master modport is the core and memory side.
interface mem_access_if;
  logic        req_vld;
  logic        req_rdy;
  logic [1:0]  req_op;
  logic        req_space;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  req_mask;
  logic        rsp_vld;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] rd_addr;
  logic        data_rd_en;
  logic        xdata_rd_en;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        data_wr_en;
  logic        xdata_wr_en;

  modport slave (
    input  req_vld, req_op, req_space, req_addr, req_wdata, req_mask, rd_data, rd_vld,
    output req_rdy, rsp_vld, rsp_data, rsp_err, rd_addr, data_rd_en, xdata_rd_en,
           wr_addr, wr_data, data_wr_en, xdata_wr_en
  );

  modport master (
    output req_vld, req_op, req_space, req_addr, req_wdata, req_mask, rd_data, rd_vld,
    input  req_rdy, rsp_vld, rsp_data, rsp_err, rd_addr, data_rd_en, xdata_rd_en,
           wr_addr, wr_data, data_wr_en, xdata_wr_en
  );
endinterface

// File: rtl/mem_access.sv
// Single-request read / write / read-modify-write engine over data and xdata spaces.
// Define MEM_ACCESS_TIMEOUT_EN to abort reads that get no rd_vld within TIMEOUT_CYCLES.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input logic          clk,
  input logic          rst,
  mem_access_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_MOD, S_RSP} state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        space_q, space_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [15:0] mem_addr;
  logic [7:0]  merged;

  assign mem_addr = space_q ? addr_q : {8'h00, addr_q[7:0]};
  assign merged   = (rdata_q & ~mask_q) | (wdata_q & mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      space_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      space_q    <= space_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Response registers are only loaded on the edge entering RSP, so they hold between pulses.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    space_d    = space_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = '0;
    unique case (state_q)
      S_IDLE: if (bus.req_vld) begin
        op_d    = bus.req_op;
        space_d = bus.req_space;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        mask_d  = bus.req_mask;
        unique case (bus.req_op)
          OP_RD, OP_RMW: state_d = S_RD;
          OP_WR:         state_d = S_WR;
          default: begin
            state_d    = S_RSP;
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b1;
          end
        endcase
      end
      S_RD: begin
        cnt_d = cnt_q + 4'd1;
        if (bus.rd_vld) begin
          rdata_d = bus.rd_data;
          if (op_q == OP_RMW) begin
            state_d = S_MOD;
          end else begin
            state_d    = S_RSP;
            rsp_data_d = bus.rd_data;
            rsp_err_d  = 1'b0;
          end
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d    = S_RSP;
          rsp_data_d = 8'hFF;
          rsp_err_d  = 1'b1;
        end
      end
      S_WR: begin
        state_d    = S_RSP;
        rsp_data_d = wdata_q;
        rsp_err_d  = 1'b0;
      end
      S_MOD: begin
        state_d    = S_RSP;
        rsp_data_d = merged;
        rsp_err_d  = 1'b0;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read enable drops in the cycle rd_vld arrives, so a normal read strobes it for one cycle.
  always_comb begin
    bus.req_rdy     = (state_q == S_IDLE) && !rst;
    bus.rsp_vld     = (state_q == S_RSP);
    bus.rsp_data    = rsp_data_q;
    bus.rsp_err     = rsp_err_q;
    bus.rd_addr     = mem_addr;
    bus.wr_addr     = mem_addr;
    bus.wr_data     = (state_q == S_MOD) ? merged : wdata_q;
    bus.data_rd_en  = (state_q == S_RD) && !bus.rd_vld && !space_q;
    bus.xdata_rd_en = (state_q == S_RD) && !bus.rd_vld &&  space_q;
    bus.data_wr_en  = ((state_q == S_WR) || (state_q == S_MOD)) && !space_q;
    bus.xdata_wr_en = ((state_q == S_WR) || (state_q == S_MOD)) &&  space_q;
  end
endmodule

// File: tb/tb_mem_access.sv
// Directed vector bench for mem_access: table of transactions plus reset and timeout sequences.
module tb_mem_access;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_access_if bus();

  mem_access #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sp;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  mask;
    logic [7:0]  mem;
    bit          noise;   // rd_vld held high although no read is pending
    int          lat;
    bit          chk_d;
    logic [7:0]  rdata;
    logic        err;
    int          rd_k;    // 0 none, 1 data, 2 xdata
    int          wr_k;
    logic [15:0] maddr;
    logic [7:0]  wdx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at the drive point of an IDLE cycle; returns at the drive point after the response.
  task automatic run_vec(input vec_t v);
    int rsp_cyc = -1;
    int rd_d = 0, rd_x = 0, wr_d = 0, wr_x = 0, excl = 0, hold = 0;
    int rd_first = -1;
    logic [7:0]  rsp_d = 8'h00;
    logic        rsp_e = 1'b0;
    logic [7:0]  prev;
    logic [15:0] ra = '0, wa = '0;
    logic [7:0]  wdv = '0;
    bus.req_vld   = 1'b1;
    bus.req_op    = v.op;
    bus.req_space = v.sp;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wd;
    bus.req_mask  = v.mask;
    bus.rd_vld    = v.noise;
    bus.rd_data   = 8'($urandom);
    #1;
    chk({v.name, "_rdy"}, {bus.req_rdy, bus.rsp_vld}, 2'b10);
    prev = bus.rsp_data;
    for (int c = 1; c <= 20 && rsp_cyc < 0; c++) begin
      cyc();
      bus.req_vld   = 1'b0;
      bus.req_op    = 2'($urandom);
      bus.req_space = 1'($urandom);
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 8'($urandom);
      bus.req_mask  = 8'($urandom);
      if (v.noise) begin
        bus.rd_vld  = 1'b1;
        bus.rd_data = 8'($urandom);
      end else if (rd_first > 0 && rd_first == c - 1) begin
        bus.rd_vld  = 1'b1;
        bus.rd_data = v.mem;
      end else begin
        bus.rd_vld  = 1'b0;
        bus.rd_data = 8'($urandom);
      end
      #1;
      if (bus.data_rd_en)  rd_d++;
      if (bus.xdata_rd_en) rd_x++;
      if (bus.data_wr_en)  wr_d++;
      if (bus.xdata_wr_en) wr_x++;
      if ((bus.data_rd_en || bus.xdata_rd_en) && rd_first < 0) begin
        rd_first = c;
        ra = bus.rd_addr;
      end
      if (bus.data_wr_en || bus.xdata_wr_en) begin
        wa  = bus.wr_addr;
        wdv = bus.wr_data;
      end
      if ((bus.data_rd_en || bus.xdata_rd_en) && (bus.data_wr_en || bus.xdata_wr_en)) excl++;
      if ((bus.data_rd_en && bus.xdata_rd_en) || (bus.data_wr_en && bus.xdata_wr_en)) excl++;
      if (bus.rsp_vld) begin
        rsp_cyc = c;
        rsp_d   = bus.rsp_data;
        rsp_e   = bus.rsp_err;
      end else if (bus.rsp_data !== prev) begin
        hold++;
      end
    end
    chk({v.name, "_lat"}, 32'(rsp_cyc), 32'(v.lat));
    if (v.chk_d) chk({v.name, "_data"}, {24'h0, rsp_d}, {24'h0, v.rdata});
    chk({v.name, "_err"}, {31'h0, rsp_e}, {31'h0, v.err});
    chk({v.name, "_rd_en"}, {16'(rd_d), 16'(rd_x)},
        {16'(v.rd_k == 1 ? 1 : 0), 16'(v.rd_k == 2 ? 1 : 0)});
    chk({v.name, "_wr_en"}, {16'(wr_d), 16'(wr_x)},
        {16'(v.wr_k == 1 ? 1 : 0), 16'(v.wr_k == 2 ? 1 : 0)});
    if (v.rd_k != 0) chk({v.name, "_rd_addr"}, {16'h0, ra}, {16'h0, v.maddr});
    if (v.wr_k != 0) chk({v.name, "_wr"}, {8'h0, wa, wdv}, {8'h0, v.maddr, v.wdx});
    chk({v.name, "_excl_hold"}, {16'(excl), 16'(hold)}, 32'h0);
    cyc();
    bus.rd_vld = 1'b0;
  endtask

  vec_t vecs[8];
  int   viol;
  int   rsp_c;
  int   rdc;

  initial begin
    //        name    op     sp   addr      wd     mask   mem   nz lat chk  rdata  err rd wr maddr     wdx
    vecs[0] = '{"rd_d",  2'b00, 1'b0, 16'h0030, 8'h00, 8'h00, 8'h5A, 0, 3, 1, 8'h5A, 0, 1, 0, 16'h0030, 8'h00};
    vecs[1] = '{"wr_x",  2'b01, 1'b1, 16'h0ABC, 8'h3C, 8'h00, 8'h00, 1, 2, 1, 8'h3C, 0, 0, 2, 16'h0ABC, 8'h3C};
    vecs[2] = '{"rmw_d", 2'b10, 1'b0, 16'h00A0, 8'h05, 8'h0F, 8'hF0, 0, 4, 1, 8'hF5, 0, 1, 1, 16'h00A0, 8'hF5};
    vecs[3] = '{"ill",   2'b11, 1'b1, 16'h1234, 8'h77, 8'hFF, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00};
    vecs[4] = '{"rd_x",  2'b00, 1'b1, 16'hBEEF, 8'h00, 8'h00, 8'hC3, 0, 3, 1, 8'hC3, 0, 2, 0, 16'hBEEF, 8'h00};
    vecs[5] = '{"wr_d",  2'b01, 1'b0, 16'h12FE, 8'h81, 8'h00, 8'h00, 0, 2, 1, 8'h81, 0, 0, 1, 16'h00FE, 8'h81};
    vecs[6] = '{"rmw_x", 2'b10, 1'b1, 16'h8001, 8'h5C, 8'hF0, 8'hAA, 0, 4, 1, 8'h5A, 0, 2, 2, 16'h8001, 8'h5A};
    vecs[7] = '{"rd_lo", 2'b00, 1'b0, 16'hFF7F, 8'h00, 8'h00, 8'h00, 0, 3, 1, 8'h00, 0, 1, 0, 16'h007F, 8'h00};

    bus.req_vld = 1'b1; bus.req_op = 2'b01; bus.req_space = 1'b1;
    bus.req_addr = 16'hFFFF; bus.req_wdata = 8'hFF; bus.req_mask = 8'hFF;
    bus.rd_vld = 1'b1; bus.rd_data = 8'hFF;
    rst = 1'b1;
    cyc(); cyc();
    #1;
    chk("reset_ctl", {bus.req_rdy, bus.rsp_vld, bus.rsp_err, bus.data_rd_en, bus.xdata_rd_en,
                      bus.data_wr_en, bus.xdata_wr_en}, 7'h0);
    chk("reset_bus", {bus.rsp_data, bus.rd_addr}, 24'h0);
    chk("reset_wr_addr", {16'h0, bus.wr_addr}, 32'h0);
    cyc();
    rst = 1'b0; bus.req_vld = 1'b0; bus.rd_vld = 1'b0;
    #1;
    chk("post_reset_rdy", {31'h0, bus.req_rdy}, 32'h1);
    cyc();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while an RMW sits in RD: no write, no response, ready right after release.
    viol = 0;
    bus.req_vld = 1'b1; bus.req_op = 2'b10; bus.req_space = 1'b0;
    bus.req_addr = 16'h00A0; bus.req_wdata = 8'h05; bus.req_mask = 8'h0F;
    cyc();
    bus.req_vld = 1'b0;
    #1;
    chk("rst_mid_rd_en", {31'h0, bus.data_rd_en}, 32'h1);
    cyc();
    rst = 1'b1; bus.rd_vld = 1'b1; bus.rd_data = 8'hF0;
    #1;
    cyc();
    bus.rd_vld = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.req_rdy, bus.rsp_vld, bus.data_rd_en, bus.xdata_rd_en,
                         bus.data_wr_en, bus.xdata_wr_en}, 6'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_rdy", {31'h0, bus.req_rdy}, 32'h1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      #1;
      if (bus.rsp_vld || bus.data_wr_en || bus.xdata_wr_en || !bus.req_rdy) viol++;
    end
    chk("rst_mid_quiet", 32'(viol), 32'h0);
    cyc();

    // Read that never sees rd_vld.
    rsp_c = -1; rdc = 0; viol = 0;
    bus.req_vld = 1'b1; bus.req_op = 2'b10; bus.req_space = 1'b0;
    bus.req_addr = 16'h0044; bus.req_wdata = 8'h12; bus.req_mask = 8'hFF;
    bus.rd_vld = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    for (int c = 1; c <= 30 && rsp_c < 0; c++) begin
      cyc();
      bus.req_vld = 1'b0;
      #1;
      if (bus.data_rd_en) rdc++;
      if (bus.data_wr_en || bus.xdata_wr_en) viol++;
      if (bus.rsp_vld) begin
        rsp_c = c;
        chk("to_rsp", {bus.rsp_err, bus.rsp_data}, 9'h1FF);
      end
    end
    chk("to_lat", 32'(rsp_c), 32'd9);
    chk("to_rd_cycles", 32'(rdc), 32'd8);
    chk("to_no_write", 32'(viol), 32'h0);
    cyc();
`else
    for (int c = 1; c <= 100; c++) begin
      cyc();
      bus.req_vld = 1'b0;
      #1;
      if (bus.data_rd_en) rdc++;
      if (bus.rsp_vld || bus.data_wr_en || bus.xdata_wr_en) viol++;
    end
    chk("no_to_still_rd", {bus.data_rd_en, bus.req_rdy}, 2'b10);
    chk("no_to_rd_cycles", 32'(rdc), 32'd100);
    chk("no_to_quiet", 32'(viol), 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("no_to_recover", {31'h0, bus.req_rdy}, 32'h1);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
